// File: rtl/dm_display_ctrl_pkg.sv
// Shared types and constants for the data-memory debug front panel:
// debouncer state encoding, hex-to-7-segment table and blanking values.
package dm_display_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } dbnc_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost packed element.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/dm_display_ctrl_if.sv
// Board-side signal bundle: raw buttons, CPU show-port and 7-segment drive.
interface dm_display_ctrl_if;

    logic        btn_next;
    logic        btn_prev;
    logic [31:0] show_data;
    logic [31:0] show_addr;
    logic [7:0]  an;
    logic [7:0]  seg;

    modport master (
        input  btn_next, btn_prev, show_data,
        output show_addr, an, seg
    );

    modport slave (
        output btn_next, btn_prev, show_data,
        input  show_addr, an, seg
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus press/release debouncer; emits one pulse per
// accepted press and never auto-repeats while the button stays down.
module btn_debounce
    import dm_display_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    dbnc_state_t      state;
    dbnc_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Stage p0/p1: metastability guard for the asynchronous button level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse     = 1'b0;
        case (state)
            IDLE: begin
                if (sync_p1) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_p1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    pulse     = 1'b1;
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync_p1) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high re-arms HELD so release chatter never re-triggers
                if (sync_p1) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/dm_display_ctrl.sv
// DM debug front panel: button-stepped show address, tear-free snapshot of
// the returned word, and 8-digit multiplexed hex display.
module dm_display_ctrl
    import dm_display_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SCAN_CYCLES     = 100000,
    parameter int unsigned ADDR_STEP       = 4,
    parameter int unsigned ADDR_LIMIT      = 32'h400
) (
    input  logic clk,
    input  logic rst,
    dm_display_ctrl_if.master dm
);

    localparam logic [31:0] STEP  = ADDR_STEP;
    localparam logic [31:0] LIMIT = ADDR_LIMIT;
    localparam int unsigned SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

    logic              next_pulse;
    logic              prev_pulse;
    logic [31:0]       show_addr;
    logic [31:0]       addr_nxt;
    logic [31:0]       addr_inc;
    logic              addr_chg;
    logic [1:0]        reload_cnt;
    logic              reload_fire;
    logic [31:0]       snap;
    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_tick;
    logic [2:0]        idx;
    logic              frame_end;
    logic [3:0]        nibble;
    logic [7:0]        an;
    logic [7:0]        seg;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (dm.btn_next),
        .pulse (next_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_prev (
        .clk   (clk),
        .rst   (rst),
        .btn   (dm.btn_prev),
        .pulse (prev_pulse)
    );

    // Opposing pulses in the same cycle cancel out
    always_comb begin
        addr_inc = show_addr + STEP;
        addr_nxt = show_addr;
        if (next_pulse && !prev_pulse) begin
            addr_nxt = (addr_inc >= LIMIT) ? 32'h0 : addr_inc;
        end else if (prev_pulse && !next_pulse) begin
            addr_nxt = (show_addr == 32'h0) ? (LIMIT - STEP) : (show_addr - STEP);
        end
        addr_chg = (addr_nxt != show_addr);
    end

    assign scan_tick   = (scan_cnt == SCAN_LAST);
    assign frame_end   = scan_tick && (idx == 3'd7);
    assign reload_fire = (reload_cnt == 2'd1);
    assign nibble      = snap[4*idx +: 4];

    // Address register and reload timer; the 2-cycle delay lets a synchronous DM read settle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            show_addr  <= 32'h0;
            reload_cnt <= 2'd0;
        end else begin
            show_addr <= addr_nxt;
            if (addr_chg) begin
                reload_cnt <= 2'd2;
            end else if (reload_cnt != 2'd0) begin
                reload_cnt <= reload_cnt - 2'd1;
            end
        end
    end

    // Snapshot only at frame wrap or reload expiry so a frame never tears
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap     <= 32'h0;
            scan_cnt <= '0;
            idx      <= 3'd0;
        end else begin
            if (frame_end || reload_fire) begin
                snap <= dm.show_data;
            end
            if (scan_tick) begin
                scan_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    // Output stage: decimal point on digit 4 splits the word into halves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= ~(8'b1 << idx);
            seg <= {(idx == 3'd4) ? 1'b0 : 1'b1, HEX_SEG[nibble]};
        end
    end

    assign dm.show_addr = show_addr;
    assign dm.an        = an;
    assign dm.seg       = seg;

endmodule
